// File: rtl/adc_pkg.sv
// Shared types and constants for the ADC responder model.
//   adc_state_e : conversion/read state machine encoding
//   MODE_*      : sample-source select values carried on the mode port
//   DEF_DATA_W  : default sample/bus width
package adc_pkg;

   localparam int unsigned DEF_DATA_W = 8;

   typedef enum logic [1:0] {
      StIdle,
      StConvert,
      StReady
   } adc_state_e;

   localparam logic [1:0] MODE_RAMP = 2'd0;
   localparam logic [1:0] MODE_TRI  = 2'd1;
   localparam logic [1:0] MODE_SQ   = 2'd2;
   localparam logic [1:0] MODE_EXT  = 2'd3;

endpackage

// File: rtl/adc_wave_gen.sv
// Test-waveform generator feeding the ADC responder.
//   clk, rst : clock and asynchronous active-low reset
//   step_en  : advance the generator by one sample
//   mode     : ramp / triangle / square / external (external holds the generator)
//   val      : current sample value for the selected mode
// Ramp and triangle share one value register so switching between them continues from the
// current level; the square generator keeps its own phase and sample count.
module adc_wave_gen
   import adc_pkg::*;
#(
   parameter int unsigned DATA_W    = DEF_DATA_W,
   parameter int unsigned RAMP_STEP = 1,
   parameter int unsigned SQ_HALF   = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              step_en,
   input  logic [1:0]        mode,
   output logic [DATA_W-1:0] val
);

   localparam int unsigned     SqCntW = (SQ_HALF > 1) ? $clog2(SQ_HALF) : 1;
   localparam logic [DATA_W:0] MaxVal = {1'b0, {DATA_W{1'b1}}};
   localparam logic [DATA_W:0] Step   = (DATA_W + 1)'(RAMP_STEP);

   logic [DATA_W-1:0] val_q, val_d;
   logic              dir_q, dir_d;       // 0 = counting up
   logic              sq_phase_q, sq_phase_d;
   logic [SqCntW-1:0] sq_cnt_q, sq_cnt_d;
   logic [DATA_W:0]   sum;                // one extra bit for the overflow test

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         val_q      <= '0;
         dir_q      <= 1'b0;
         sq_phase_q <= 1'b0;
         sq_cnt_q   <= '0;
      end else begin
         val_q      <= val_d;
         dir_q      <= dir_d;
         sq_phase_q <= sq_phase_d;
         sq_cnt_q   <= sq_cnt_d;
      end
   end

   always_comb begin
      val_d      = val_q;
      dir_d      = dir_q;
      sq_phase_d = sq_phase_q;
      sq_cnt_d   = sq_cnt_q;
      sum        = {1'b0, val_q} + Step;
      if (step_en) begin
         case (mode)
            MODE_RAMP: val_d = sum[DATA_W-1:0];
            MODE_TRI: begin
               if (!dir_q) begin
                  // Reaching max counts as the turn so max appears exactly once.
                  if (sum >= MaxVal) begin
                     val_d = MaxVal[DATA_W-1:0];
                     dir_d = 1'b1;
                  end else begin
                     val_d = sum[DATA_W-1:0];
                  end
               end else begin
                  if ({1'b0, val_q} <= Step) begin
                     val_d = '0;
                     dir_d = 1'b0;
                  end else begin
                     val_d = val_q - Step[DATA_W-1:0];
                  end
               end
            end
            MODE_SQ: begin
               if (sq_cnt_q == SqCntW'(SQ_HALF - 1)) begin
                  sq_cnt_d   = '0;
                  sq_phase_d = ~sq_phase_q;
               end else begin
                  sq_cnt_d = sq_cnt_q + 1'b1;
               end
            end
            default: ; // external source: generator holds
         endcase
      end
   end

   assign val = (mode == MODE_SQ) ? {DATA_W{sq_phase_q}} : val_q;

endmodule

// File: rtl/adc_responder.sv
// Behavioural stand-in for a parallel sampling ADC driven through convstb/csb/rdb/db.
//   clk, rst    : clock and asynchronous active-low reset
//   convstb     : active-low conversion start, falling edge triggers
//   csb, rdb    : active-low chip select and read strobe
//   mode        : sample source (ramp, triangle, square, external)
//   ext_sample  : external sample captured in external mode
//   db, db_oe   : registered data bus and its drive enable (db is 0 when not driven)
//   busy        : high for exactly CONV_CYCLES cycles per conversion
//   overrun     : one-cycle pulse when a start is ignored or an unread result is dropped
module adc_responder
   import adc_pkg::*;
#(
   parameter int unsigned DATA_W      = DEF_DATA_W,
   parameter int unsigned CONV_CYCLES = 50,
   parameter int unsigned RAMP_STEP   = 1,
   parameter int unsigned SQ_HALF     = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              convstb,
   input  logic              csb,
   input  logic              rdb,
   input  logic [1:0]        mode,
   input  logic [DATA_W-1:0] ext_sample,
   output logic [DATA_W-1:0] db,
   output logic              db_oe,
   output logic              busy,
   output logic              overrun
);

   localparam int unsigned CntW = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;

   adc_state_e        state_q, state_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic              convstb_q;
   logic              busy_q, busy_d;
   logic              overrun_q, overrun_d;
   logic [DATA_W-1:0] result_q, result_d;
   logic [DATA_W-1:0] hold_q, hold_d;
   logic [DATA_W-1:0] db_q, db_d;
   logic              db_oe_q, db_oe_d;

   logic              conv_fall;
   logic              rd_act;
   logic              start;
   logic              step_en;
   logic [DATA_W-1:0] gen_val;

   adc_wave_gen #(
      .DATA_W    (DATA_W),
      .RAMP_STEP (RAMP_STEP),
      .SQ_HALF   (SQ_HALF)
   ) u_wave_gen (
      .clk     (clk),
      .rst     (rst),
      .step_en (step_en),
      .mode    (mode),
      .val     (gen_val)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         convstb_q <= 1'b1;
         busy_q    <= 1'b0;
         overrun_q <= 1'b0;
         result_q  <= '0;
         hold_q    <= '0;
         db_q      <= '0;
         db_oe_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         convstb_q <= convstb;
         busy_q    <= busy_d;
         overrun_q <= overrun_d;
         result_q  <= result_d;
         hold_q    <= hold_d;
         db_q      <= db_d;
         db_oe_q   <= db_oe_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      busy_d    = busy_q;
      overrun_d = 1'b0;
      result_d  = result_q;
      hold_d    = hold_q;
      start     = 1'b0;
      step_en   = 1'b0;
      conv_fall = convstb_q & ~convstb;
      rd_act    = ~csb & ~rdb;

      unique case (state_q)
         StIdle: begin
            if (conv_fall) start = 1'b1;
         end
         StConvert: begin
            // A start during conversion is dropped; the countdown is not restarted.
            if (conv_fall) overrun_d = 1'b1;
            if (cnt_q == '0) begin
               result_d = hold_q;
               busy_d   = 1'b0;
               state_d  = StReady;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         StReady: begin
            if (conv_fall) begin
               // A simultaneous read consumes the old result, so nothing is lost.
               start     = 1'b1;
               overrun_d = ~rd_act;
            end else if (rd_act) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      if (start) begin
         hold_d  = (mode == MODE_EXT) ? ext_sample : gen_val;
         step_en = 1'b1;
         cnt_d   = CntW'(CONV_CYCLES - 1);
         busy_d  = 1'b1;
         state_d = StConvert;
      end

      // Reads are served in every state; outside READY they return the last result.
      db_oe_d = rd_act;
      db_d    = rd_act ? result_q : '0;
   end

   assign db      = db_q;
   assign db_oe   = db_oe_q;
   assign busy    = busy_q;
   assign overrun = overrun_q;

endmodule

// File: tb/tb_adc_responder.sv
// Scoreboard bench for adc_responder: each conversion start pushes the expected sample,
// each bus read pops and compares.
module tb_adc_responder;

   localparam int DATA_W      = 8;
   localparam int CONV_CYCLES = 50;
   localparam int RAMP_STEP   = 1;
   localparam int SQ_HALF     = 16;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              convstb = 1'b1;
   logic              csb = 1'b1;
   logic              rdb = 1'b1;
   logic [1:0]        mode = 2'd0;
   logic [DATA_W-1:0] ext_sample = '0;
   logic [DATA_W-1:0] db;
   logic              db_oe;
   logic              busy;
   logic              overrun;

   adc_responder #(
      .DATA_W      (DATA_W),
      .CONV_CYCLES (CONV_CYCLES),
      .RAMP_STEP   (RAMP_STEP),
      .SQ_HALF     (SQ_HALF)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .convstb    (convstb),
      .csb        (csb),
      .rdb        (rdb),
      .mode       (mode),
      .ext_sample (ext_sample),
      .db         (db),
      .db_oe      (db_oe),
      .busy       (busy),
      .overrun    (overrun)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   logic [DATA_W-1:0] exp_q[$];

   // Reference generator state
   int mdl_val = 0;
   bit mdl_dir = 1'b0;
   bit mdl_ph  = 1'b0;
   int mdl_cnt = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [DATA_W-1:0] mdl_sample();
      if (mode == 2'd3) return ext_sample;
      if (mode == 2'd2) return mdl_ph ? 8'hFF : 8'h00;
      return mdl_val[DATA_W-1:0];
   endfunction

   task automatic mdl_step();
      case (mode)
         2'd0: mdl_val = (mdl_val + RAMP_STEP) % 256;
         2'd1: begin
            if (!mdl_dir) begin
               if (mdl_val + RAMP_STEP >= 255) begin
                  mdl_val = 255;
                  mdl_dir = 1'b1;
               end else mdl_val = mdl_val + RAMP_STEP;
            end else begin
               if (mdl_val <= RAMP_STEP) begin
                  mdl_val = 0;
                  mdl_dir = 1'b0;
               end else mdl_val = mdl_val - RAMP_STEP;
            end
         end
         2'd2: begin
            mdl_cnt++;
            if (mdl_cnt == SQ_HALF) begin
               mdl_cnt = 0;
               mdl_ph  = ~mdl_ph;
            end
         end
         default: ;
      endcase
   endtask

   task automatic mdl_reset();
      mdl_val = 0;
      mdl_dir = 1'b0;
      mdl_ph  = 1'b0;
      mdl_cnt = 0;
      exp_q.delete();
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      rst = 1'b0;
      mdl_reset();
      @(negedge clk);
      rst = 1'b1;
   endtask

   // Returns at the negedge after the sampling posedge (busy should be high there).
   task automatic start_conv();
      @(negedge clk);
      exp_q.push_back(mdl_sample());
      mdl_step();
      convstb = 1'b0;
      @(negedge clk);
      convstb = 1'b1;
   endtask

   // Counts busy cycles; optionally injects a second start at busy cycle inj_at.
   task automatic wait_done(input int inj_at, output int cycles);
      cycles = 0;
      while (busy === 1'b1 && cycles < 4 * CONV_CYCLES) begin
         if (inj_at > 0 && cycles == inj_at) convstb = 1'b0;
         if (inj_at > 0 && cycles == inj_at + 1) begin
            convstb = 1'b1;
            check_eq("ovr_pulse", overrun, 1);
         end
         if (inj_at > 0 && cycles == inj_at + 2) check_eq("ovr_clear", overrun, 0);
         cycles++;
         @(negedge clk);
      end
   endtask

   task automatic do_read(input string tag, output logic [DATA_W-1:0] got);
      logic [DATA_W-1:0] exp;
      csb = 1'b0;
      rdb = 1'b0;
      @(negedge clk);
      got = db;
      check_eq({tag, "_oe"}, db_oe, 1);
      if (exp_q.size() == 0) begin
         check_eq({tag, "_sb_empty"}, 1, 0);
      end else begin
         exp = exp_q.pop_front();
         check_eq(tag, db, exp);
      end
      csb = 1'b1;
      rdb = 1'b1;
      @(negedge clk);
   endtask

   task automatic conv_and_read(input string tag, output logic [DATA_W-1:0] got);
      int c;
      start_conv();
      wait_done(0, c);
      do_read(tag, got);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int c;
      logic [DATA_W-1:0] got;
      logic [DATA_W-1:0] tri_exp[5];
      tri_exp[0] = 8'hFD;
      tri_exp[1] = 8'hFE;
      tri_exp[2] = 8'hFF;
      tri_exp[3] = 8'hFE;
      tri_exp[4] = 8'hFD;

      // Reset state
      #1;
      check_eq("rst_busy", busy, 0);
      check_eq("rst_db_oe", db_oe, 0);
      check_eq("rst_db", db, 0);
      check_eq("rst_overrun", overrun, 0);
      @(negedge clk);
      rst = 1'b1;

      // 1: first conversion timing and read latency
      @(negedge clk);
      check_eq("t1_busy_pre", busy, 0);
      start_conv();
      check_eq("t1_busy_rise", busy, 1);
      check_eq("t1_no_overrun", overrun, 0);
      wait_done(0, c);
      check_eq("t1_busy_len", c, CONV_CYCLES);
      do_read("t1_read0", got);
      check_eq("t1_oe_off", db_oe, 0);
      check_eq("t1_db_off", db, 0);
      conv_and_read("t1_read1", got);

      // 2: ramp wrap and triangle turnaround at max
      pulse_reset();
      mode = 2'd0;
      for (int i = 0; i < 257; i++) conv_and_read("ramp", got);
      for (int i = 0; i < 252; i++) conv_and_read("ramp_pre_tri", got);
      mode = 2'd1;
      for (int i = 0; i < 5; i++) begin
         conv_and_read("tri", got);
         check_eq("tri_seq", got, tri_exp[i]);
      end

      // 3: start during conversion is ignored
      pulse_reset();
      mode = 2'd0;
      start_conv();
      wait_done(19, c);
      check_eq("t3_busy_len", c, CONV_CYCLES);
      do_read("t3_read", got);
      check_eq("t3_sb_left", exp_q.size(), 0);

      // 4: unread result discarded by a new start; stale read during conversion
      start_conv();
      wait_done(0, c);
      start_conv();
      check_eq("t4_overrun", overrun, 1);
      @(negedge clk);
      check_eq("t4_overrun_clr", overrun, 0);
      repeat (10) @(negedge clk);
      do_read("t4_stale", got);
      wait_done(0, c);
      do_read("t4_new", got);

      // Simultaneous read and start in READY: start wins, no overrun, old data read
      start_conv();
      wait_done(0, c);
      @(negedge clk);
      exp_q.push_back(mdl_sample());
      mdl_step();
      convstb = 1'b0;
      csb = 1'b0;
      rdb = 1'b0;
      @(negedge clk);
      convstb = 1'b1;
      csb = 1'b1;
      rdb = 1'b1;
      check_eq("sim_busy", busy, 1);
      check_eq("sim_overrun", overrun, 0);
      check_eq("sim_oe", db_oe, 1);
      check_eq("sim_old", db, exp_q.pop_front());
      wait_done(0, c);
      do_read("sim_new", got);

      // 5a: external sample captured at the start edge
      mode = 2'd3;
      ext_sample = 8'hA5;
      start_conv();
      ext_sample = 8'h00;
      wait_done(0, c);
      do_read("ext", got);
      check_eq("ext_const", got, 8'hA5);

      // 6: reset mid-conversion aborts it
      mode = 2'd0;
      start_conv();
      repeat (23) @(negedge clk);
      csb = 1'b0;
      rdb = 1'b0;
      @(negedge clk);
      check_eq("t6_oe_pre", db_oe, 1);
      rst = 1'b0;
      #1;
      check_eq("t6_busy", busy, 0);
      check_eq("t6_oe", db_oe, 0);
      check_eq("t6_db", db, 0);
      mdl_reset();
      csb = 1'b1;
      rdb = 1'b1;
      @(negedge clk);
      rst = 1'b1;
      conv_and_read("t6_after", got);
      check_eq("t6_after_const", got, 8'h00);

      // 5b: square wave from a fresh square state
      mode = 2'd2;
      for (int i = 0; i < 2 * SQ_HALF; i++) begin
         conv_and_read("square", got);
         check_eq("square_const", got, (i < SQ_HALF) ? 8'h00 : 8'hFF);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/adc_responder.md
Name: adc_responder

Overview:
- Synthesizable model of the parallel sampling ADC that the oscilloscope front end drives through convstb/csb/rdb/db.
- Responds to the conversion/read handshake with realistic conversion latency.
- Supplies samples from an internal test-waveform generator or an external input.
- Used in simulation benches and as an on-FPGA loopback stand-in for the real ADC.

Parameters:
DATA_W, 8, sample/bus width in bits
CONV_CYCLES, 50, clk cycles from conversion start to result ready (must be >= 2)
RAMP_STEP, 1, generator increment per sample (ramp and triangle modes)
SQ_HALF, 16, samples per half-period in square mode

Ports:
clk  in  1  system clock; all inputs are synchronous to it
rst  in  1  asynchronous active-low reset
convstb  in  1  conversion start; active-low, a falling edge starts a conversion
csb  in  1  chip select, active low
rdb  in  1  read strobe, active low
mode  in  2  sample source: 0 ramp, 1 triangle, 2 square, 3 external
ext_sample  in  DATA_W  external sample, used when mode=3
db  out  DATA_W  data bus; 0 when db_oe=0
db_oe  out  1  bus-drive enable; the top level uses it for tristate
busy  out  1  high while a conversion is in progress
overrun  out  1  one-cycle pulse when a conversion request is ignored or an unread result is discarded

Behaviour:
- Reset state (rst=0, immediate): state IDLE, db=0, db_oe=0, busy=0, overrun=0, result=0, hold=0, generator=0, triangle direction up, square phase low, square count 0.
- Reset asserted mid-conversion aborts the conversion with no result update.
- Edge detection: convstb_q is registered each cycle; conv_fall = convstb_q & ~convstb. convstb_q resets to 1.
- States: IDLE, CONVERT, READY.
- IDLE + conv_fall:
  - hold <= current generator value, or ext_sample when mode=3.
  - Generator advances one step.
  - cnt <= CONV_CYCLES-1; busy <= 1; go to CONVERT.
  - busy is therefore high the cycle after the falling edge.
- CONVERT: cnt decrements each cycle. At cnt==0: result <= hold; busy <= 0; go to READY. busy stays high for exactly CONV_CYCLES cycles.
- CONVERT + conv_fall: request ignored; overrun pulses 1 cycle; cnt is not restarted.
- READY + conv_fall: starts a new conversion exactly as from IDLE; overrun pulses (unread result discarded). result keeps its old value until the new conversion completes.
- Read:
  - db_oe <= ~csb & ~rdb (registered, 1-cycle latency).
  - db <= result while that term is 1, else 0.
  - Reads are allowed in any state. In IDLE or CONVERT the bus returns the last completed result (stale).
- READY exits to IDLE on the first cycle where csb=0 and rdb=0. db remains the result until rdb deasserts.
- Simultaneous read and conv_fall in READY: the conversion start wins (go to CONVERT, overrun=0); the read still returns the old result.
- Generator:
  - Ramp: val += RAMP_STEP mod 2^DATA_W; 255 wraps to 0 for step 1.
  - Triangle: steps up until val+STEP would exceed max, then clamps to max and reverses. Steps down to 0 and reverses. Sequence at max: ..., 254, 255, 254, ...
  - Square: outputs 0 or all-ones; toggles every SQ_HALF samples.
  - Changing mode does not reset val.
- Width rules: internal arithmetic is DATA_W+1 bits for the overflow test. cnt width is clog2(CONV_CYCLES).

Decomposition:
- Shared package adc_pkg holds:
  - the state enum (IDLE, CONVERT, READY);
  - mode constants (MODE_RAMP=0, MODE_TRI=1, MODE_SQ=2, MODE_EXT=3);
  - default DATA_W.
- One sub-module, adc_wave_gen:
  - inputs: clk, rst, step_en, mode;
  - output: val;
  - contains the ramp, triangle and square logic.

Test Plan:
1. Release reset, mode=0, one convstb pulse low → busy rises 1 cycle after the falling edge and is high for 50 cycles. Then csb=rdb=0 → db_oe=1 and db=0x00 one cycle later; the second conversion returns 0x01.
2. mode=0, 257 convert/read cycles → values 0x00..0xFF then 0x00 (wrap). mode=1 around max → 0xFE, 0xFF, 0xFE.
3. Second convstb falling edge at cycle 20 of a conversion → overrun pulses 1 cycle; busy still drops at cycle 50; the result is the first sample.
4. Conversion completes and is not read, then a new convstb → overrun pulse; a read during the new conversion returns the old value; after completion the read returns the new value.
5. mode=3, ext_sample=0xA5 at the convstb edge, then ext_sample changed to 0x00 → read returns 0xA5. mode=2, SQ_HALF=16 → 16×0x00 then 16×0xFF.
6. rst pulled low at conversion cycle 25 → busy=0, db_oe=0, db=0 immediately; after release, the next conversion in mode 0 returns 0x00.
